// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating store, load and fetch clients
// onto an 8-bit single-port RAM with one cycle of read latency.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        sb_enable,
  input  logic [31:0] sb_addr,
  input  logic [31:0] sb_data,
  input  logic [1:0]  sb_len,
  output logic        sb_done,
  input  logic        lb_enable,
  input  logic [31:0] lb_addr,
  input  logic [1:0]  lb_len,
  output logic        lb_done,
  output logic [31:0] lb_data,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        clear_in
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic [1:0] {C_STORE, C_LOAD, C_FETCH} client_t;

  state_t      state;
  client_t     id;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  last_q;   // N-1
  logic [1:0]  cnt;      // offset of the address currently on mem_a
  logic [2:0]  step;     // read edges elapsed since accept
  logic        stalled;
  logic        skip;
  logic [31:0] res;

  logic [1:0]  cap_idx;
  logic [1:0]  cnt_nx;
  logic [31:0] res_cap;
  logic [7:0]  wr_byte;
  logic [2:0]  resume;

  always_comb begin
    cap_idx = step[1:0] - 2'd1;
    cnt_nx  = cnt + 2'd1;
    res_cap = res;
    res_cap[{cap_idx, 3'b000} +: 8] = mem_din;
    wr_byte = data_q[{cnt_nx, 3'b000} +: 8];
    resume  = (step == 3'd0) ? 3'd0 : step - 3'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      id       <= C_STORE;
      addr_q   <= '0;
      data_q   <= '0;
      last_q   <= '0;
      cnt      <= '0;
      step     <= '0;
      stalled  <= 1'b0;
      skip     <= 1'b0;
      res      <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      mem_wr   <= 1'b0;
      sb_done  <= 1'b0;
      lb_done  <= 1'b0;
      if_done  <= 1'b0;
      lb_data  <= '0;
      if_data  <= '0;
    end else if (!rdy) begin
      mem_wr <= 1'b0;
      if (state == READ) stalled <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          step    <= '0;
          stalled <= 1'b0;
          skip    <= 1'b0;
          res     <= '0;
          if (sb_enable) begin
            id       <= C_STORE;
            addr_q   <= sb_addr;
            data_q   <= sb_data;
            last_q   <= sb_len;
            mem_a    <= sb_addr;
            mem_dout <= sb_data[7:0];
            mem_wr   <= 1'b1;
            state    <= WRITE;
          end else if (lb_enable) begin
            id     <= C_LOAD;
            addr_q <= lb_addr;
            last_q <= lb_len;
            mem_a  <= lb_addr;
            state  <= READ;
          end else if (if_enable) begin
            id     <= C_FETCH;
            addr_q <= if_addr;
            last_q <= 2'd3;
            mem_a  <= if_addr;
            state  <= READ;
          end
        end
        WRITE: begin
          // mem_wr low here means a stall cleared it: re-drive the same byte
          if (!mem_wr) begin
            mem_wr <= 1'b1;
          end else if (cnt == last_q) begin
            mem_wr  <= 1'b0;
            sb_done <= 1'b1;
            state   <= DONE;
          end else begin
            cnt      <= cnt_nx;
            mem_a    <= addr_q + {30'b0, cnt_nx};
            mem_dout <= wr_byte;
          end
        end
        READ: begin
          if (clear_in) begin
            state <= IDLE;
          end else if (stalled) begin
            // The read pipeline lost sync during the stall: re-issue the
            // first uncaptured byte and discard the next mem_din sample.
            stalled <= 1'b0;
            skip    <= 1'b1;
            step    <= resume;
            cnt     <= resume[1:0];
            mem_a   <= addr_q + {30'b0, resume[1:0]};
          end else begin
            skip <= 1'b0;
            if (!skip && step != 3'd0) res <= res_cap;
            if (!skip && step == {1'b0, last_q} + 3'd1) begin
              if (id == C_LOAD) begin
                lb_data <= res_cap;
                lb_done <= 1'b1;
              end else begin
                if_data <= res_cap;
                if_done <= 1'b1;
              end
              state <= DONE;
            end else begin
              step <= step + 3'd1;
              if (step < {1'b0, last_q}) begin
                cnt   <= cnt_nx;
                mem_a <= addr_q + {30'b0, cnt_nx};
              end
            end
          end
        end
        DONE: begin
          sb_done <= 1'b0;
          lb_done <= 1'b0;
          if_done <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: RAM model, done-pulse scoreboard, immediate assertions.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        sb_enable = 1'b0;
  logic [31:0] sb_addr = '0;
  logic [31:0] sb_data = '0;
  logic [1:0]  sb_len = '0;
  logic        sb_done;
  logic        lb_enable = 1'b0;
  logic [31:0] lb_addr = '0;
  logic [1:0]  lb_len = '0;
  logic        lb_done;
  logic [31:0] lb_data;
  logic        if_enable = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_data;
  logic        clear_in = 1'b0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .sb_enable(sb_enable), .sb_addr(sb_addr), .sb_data(sb_data), .sb_len(sb_len), .sb_done(sb_done),
    .lb_enable(lb_enable), .lb_addr(lb_addr), .lb_len(lb_len), .lb_done(lb_done), .lb_data(lb_data),
    .if_enable(if_enable), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .clear_in(clear_in)
  );

  always #5 clk = ~clk;

  // RAM: synchronous write, registered read (one cycle latency)
  logic [7:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    mem_din <= ram[mem_a[9:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 0 store, 1 load, 2 fetch
    logic [31:0] data;
    int          due;    // cyc value at the negedge where done must show
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [9:0] a);
    return {ram[a + 10'd3], ram[a + 10'd2], ram[a + 10'd1], ram[a]};
  endfunction

  // Scoreboard: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    int   kind_obs;
    if (rst && (sb_done || lb_done || if_done)) begin
      check("one_done", 64'($countones({sb_done, lb_done, if_done})), 64'd1);
      kind_obs = sb_done ? 0 : (lb_done ? 1 : 2);
      if (q.size() == 0) begin
        check("unexpected_done", {61'd0, sb_done, lb_done, if_done}, 64'd0);
      end else begin
        e = q.pop_front();
        check("done_kind", 64'(kind_obs), 64'(e.kind));
        check("done_cycle", 64'(cyc), 64'(e.due));
        if (kind_obs == 1) check("lb_data", {32'd0, lb_data}, {32'd0, e.data});
        if (kind_obs == 2) check("if_data", {32'd0, if_data}, {32'd0, e.data});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (sb_done) sb_enable = 1'b0;
    if (lb_done) lb_enable = 1'b0;
    if (if_done) if_enable = 1'b0;
  endtask

  task automatic push(input int kind, input logic [31:0] data, input int due);
    exp_t e;
    e.kind = kind; e.data = data; e.due = due;
    q.push_back(e);
  endtask

  task automatic issue_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] len, input int extra);
    sb_addr = a; sb_data = d; sb_len = len; sb_enable = 1'b1;
    push(0, 32'd0, cyc + 1 + int'(len) + 1 + extra);
  endtask

  task automatic issue_load(input logic [31:0] a, input logic [1:0] len, input logic [31:0] d);
    lb_addr = a; lb_len = len; lb_enable = 1'b1;
    push(1, d, cyc + 1 + int'(len) + 2);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (q.size() != 0 && k < limit) begin
      tick();
      k++;
    end
    check("drained", 64'(q.size()), 64'd0);
    q.delete();
    tick();
  endtask

  initial begin
    tick();
    tick();
    check("rst_mem_a", {32'd0, mem_a}, 64'd0);
    check("rst_mem_dout_wr", {55'd0, mem_dout, mem_wr}, 64'd0);
    check("rst_dones", {61'd0, sb_done, lb_done, if_done}, 64'd0);
    check("rst_data", {lb_data, if_data}, 64'd0);

    // First request on the first edge out of reset; fills RAM for later loads
    rst = 1'b1;
    issue_store(32'h100, 32'h44332211, 2'd3, 0);
    tick();
    check("st0_bus", {mem_a, 23'd0, mem_dout, mem_wr}, {32'h100, 23'd0, 8'h11, 1'b1});
    wait_idle(20);
    issue_store(32'h104, 32'h88776655, 2'd3, 0);
    wait_idle(20);
    issue_store(32'hFFFF_FFFF, 32'h0000C35A, 2'd1, 0);
    tick();
    check("st_wrap_a0", {32'd0, mem_a}, 64'hFFFF_FFFF);
    tick();
    check("st_wrap_a1", {mem_a, 24'd0, mem_dout}, {32'h0, 24'd0, 8'hC3});
    wait_idle(20);

    // Word load with address sequence
    issue_load(32'h100, 2'd3, 32'h44332211);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ld_addr", {32'd0, mem_a}, 64'(32'h100 + k));
    end
    wait_idle(20);

    // Halfword load wrapping past the top of the address space
    issue_load(32'hFFFF_FFFF, 2'd1, 32'h0000C35A);
    tick();
    tick();
    check("ld_wrap_a1", {32'd0, mem_a}, 64'd0);
    wait_idle(20);

    // Three simultaneous requests: store, then load, then fetch
    begin
      int c;
      c = cyc;
      sb_addr = 32'h200; sb_data = 32'h000000A5; sb_len = 2'd0; sb_enable = 1'b1;
      lb_addr = 32'h100; lb_len = 2'd3; lb_enable = 1'b1;
      if_addr = 32'h104; if_enable = 1'b1;
      push(0, 32'd0, c + 2);
      push(1, 32'h44332211, c + 9);
      push(2, 32'h88776655, c + 16);
      tick();
      check("prio_st_bus", {mem_a, 23'd0, mem_dout, mem_wr}, {32'h200, 23'd0, 8'hA5, 1'b1});
      tick();
      check("prio_st_wr_off", {63'd0, mem_wr}, 64'd0);
      wait_idle(40);
    end
    check("prio_ram", {56'd0, ram[10'h200]}, 64'hA5);
    issue_load(32'h200, 2'd0, 32'h000000A5);
    wait_idle(20);

    // Flush during fetch at cnt=2; pending load taken while clear_in still high in IDLE
    if_addr = 32'h100; if_enable = 1'b1;
    tick();
    tick();
    tick();
    if_enable = 1'b0;
    clear_in = 1'b1;
    issue_load(32'h104, 2'd3, 32'h88776655);
    q[q.size() - 1].due = cyc + 7;
    tick();
    check("flush_no_if_done", {63'd0, if_done}, 64'd0);
    tick();
    clear_in = 1'b0;
    check("flush_load_accept", {32'd0, mem_a}, 64'h104);
    wait_idle(20);

    // clear_in is ignored by a store
    clear_in = 1'b1;
    issue_store(32'h300, 32'hDEADBEEF, 2'd3, 0);
    wait_idle(20);
    clear_in = 1'b0;
    check("clr_store_ram", {32'd0, ram_word(10'h300)}, 64'hDEADBEEF);

    // Three-cycle stall in the middle of a word store
    issue_store(32'h304, 32'hCAFEF00D, 2'd3, 4);
    tick();
    tick();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_wr_low", {63'd0, mem_wr}, 64'd0);
    end
    rdy = 1'b1;
    tick();
    check("stall_rewrite", {mem_a, 23'd0, mem_dout, mem_wr}, {32'h305, 23'd0, 8'hF0, 1'b1});
    wait_idle(20);
    check("stall_ram", {32'd0, ram_word(10'h304)}, 64'hCAFEF00D);

    // Asynchronous reset between edges during a word load
    lb_addr = 32'h100; lb_len = 2'd3; lb_enable = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b0;
    lb_enable = 1'b0;
    #1;
    check("arst_bus", {mem_a, 23'd0, mem_dout, mem_wr}, 64'd0);
    check("arst_data", {lb_data, if_data}, 64'd0);
    check("arst_dones", {61'd0, sb_done, lb_done, if_done}, 64'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    check("arst_after", {31'd0, lb_done, lb_data}, 64'd0);
    check("sb_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
